// File: rtl/fifo_merge_rr.sv
// fifo_merge_rr
//   Reader-side companion to the per-thread buffer. It drains N per-TID
//   queues (empty_n/read/data) and merges them onto M downstream lanes
//   (full_n/write/data). Queues are served round-robin, and each lane has one
//   registered output slot.
//
// Optional feature (macro FIFO_MERGE_TID_CHECK_EN):
//   When defined, every pop checks that the TID field of the popped word
//   equals the queue index. It also keeps per-lane write counters and a cycle
//   counter, which are reported at the end of simulation. When the macro is
//   undefined, the datapath is unchanged.
//
// Ports:
//   clk        clock
//   arst_n     asynchronous active-low reset
//   empty_n_i  [N]            queue i holds data
//   read_o     [N]            pop queue i this cycle
//   din_i      [N*DATA_WIDTH] head of queue i at [i*DATA_WIDTH +: DATA_WIDTH]
//   full_n_i   [M]            lane j can accept
//   write_o    [M]            lane j slot valid
//   dout_o     [M*DATA_WIDTH] lane j slot data at [j*DATA_WIDTH +: DATA_WIDTH]

module fifo_merge_rr #(
  parameter int M          = 2,
  parameter int N          = 3,
  parameter int DATA_WIDTH = 32,
  parameter int TID_W      = 2
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [N-1:0]          empty_n_i,
  output logic [N-1:0]          read_o,
  input  logic [N*DATA_WIDTH-1:0] din_i,
  input  logic [M-1:0]          full_n_i,
  output logic [M-1:0]          write_o,
  output logic [M*DATA_WIDTH-1:0] dout_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0]         rrPtr_q, rrPtr_d;
  logic [M-1:0]          vld_q, vld_d;
  logic [DATA_WIDTH-1:0] data_q [M];
  logic [DATA_WIDTH-1:0] data_d [M];
  logic [M-1:0]          avail;
  logic                  placed;
  int                    idx;

  // Grant selection and lane assignment. The scan starts at rrPtr and
  // continues while free lanes remain, so the number of grants is
  // min(free lanes, nonempty queues). Each grant takes the lowest-indexed
  // free lane that is still unclaimed. The path from full_n to read is
  // combinational on purpose; it is what allows zero-bubble streaming.
  always_comb begin
    read_o  = '0;
    vld_d   = vld_q & ~full_n_i;
    rrPtr_d = rrPtr_q;
    avail   = ~vld_q | full_n_i;
    idx     = 0;
    placed  = 1'b0;
    for (int j = 0; j < M; j++) data_d[j] = data_q[j];
    // No pops are allowed while reset is held.
    if (arst_n) begin
      for (int k = 0; k < N; k++) begin
        idx = int'(rrPtr_q) + k;
        if (idx >= N) idx = idx - N;
        if (empty_n_i[idx] && (avail != '0)) begin
          read_o[idx] = 1'b1;
          rrPtr_d     = (idx == N - 1) ? '0 : PW'(idx + 1);
          placed      = 1'b0;
          for (int j = 0; j < M; j++) begin
            if (avail[j] && !placed) begin
              avail[j]  = 1'b0;
              placed    = 1'b1;
              vld_d[j]  = 1'b1;
              data_d[j] = din_i[idx*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vld_q   <= '0;
      rrPtr_q <= '0;
      for (int j = 0; j < M; j++) data_q[j] <= '0;
    end else begin
      vld_q   <= vld_d;
      rrPtr_q <= rrPtr_d;
      for (int j = 0; j < M; j++) data_q[j] <= data_d[j];
    end
  end

  // A drained slot that is not reloaded keeps its old data. That value is a
  // don't-care, because write_o is low for that lane.
  always_comb begin
    dout_o  = '0;
    write_o = vld_q;
    for (int j = 0; j < M; j++) dout_o[j*DATA_WIDTH +: DATA_WIDTH] = data_q[j];
  end

`ifdef FIFO_MERGE_TID_CHECK_EN
  int writeCnt [M];
  int cycleCnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cycleCnt <= 0;
      for (int j = 0; j < M; j++) writeCnt[j] <= 0;
    end else begin
      cycleCnt <= cycleCnt + 1;
      for (int j = 0; j < M; j++)
        if (vld_q[j] && full_n_i[j]) writeCnt[j] <= writeCnt[j] + 1;
      for (int i = 0; i < N; i++)
        if (read_o[i] && (din_i[i*DATA_WIDTH +: TID_W] != TID_W'(i)))
          $fatal(1, "TID mismatch");
    end
  end

  final begin
    for (int j = 0; j < M; j++)
      $display("[%m]: lane %0d writes/cycles %0d/%0d", j, writeCnt[j], cycleCnt);
  end
`else
  // The TID check and the statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fifo_merge_rr.sv
// tb_fifo_merge_rr
//   Directed and random stimulus for fifo_merge_rr. Queue contents live in the
//   bench, and a reference model derives the expected pops and lane contents
//   from the round-robin merge rules.

module tb_fifo_merge_rr;

  localparam int M  = 2;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int TW = 2;

  logic            clk = 1'b0;
  logic            arst_n;
  logic [N-1:0]    empty_n;
  logic [N-1:0]    read;
  logic [N*DW-1:0] din;
  logic [M-1:0]    full_n;
  logic [M-1:0]    write;
  logic [M*DW-1:0] dout;

  fifo_merge_rr #(.M(M), .N(N), .DATA_WIDTH(DW), .TID_W(TW)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .empty_n_i (empty_n),
    .read_o    (read),
    .din_i     (din),
    .full_n_i  (full_n),
    .write_o   (write),
    .dout_o    (dout)
  );

  always #5 clk = ~clk;

  typedef logic [DW-1:0] dq_t [$];

  // Bench-side state: queue contents, the model of lane slots, and the pointer.
  dq_t          q [N];
  bit           mVld [M];
  logic [DW-1:0] mData [M];
  int           mPtr;
  bit           inReset;
  logic [M-1:0] fullCfg;
  int           grants [$];
  int           freeLanes [$];
  logic [N-1:0] lastRead;
  int           popCount [N];
  int           nChecks;
  int           nFails;

  task automatic checkValue(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pushItem(input int i);
    logic [DW-1:0] r;
    r = $urandom;
    r[TW-1:0] = TW'(i);
    q[i].push_back(r);
  endtask

  // Drives the queue heads, the lane readiness, and reset from bench state.
  task automatic applyStimulus();
    arst_n  = !inReset;
    full_n  = fullCfg;
    din     = '0;
    empty_n = '0;
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        empty_n[i] = 1'b1;
        din[i*DW +: DW] = q[i][0];
      end
    end
  endtask

  // Works out which queues should be granted this cycle and which lanes they
  // go to, then compares the DUT outputs with the model.
  task automatic checkOutput();
    logic [N-1:0] expRead;
    logic [M-1:0] expWrite;
    grants.delete();
    freeLanes.delete();
    for (int j = 0; j < M; j++)
      if (!mVld[j] || fullCfg[j]) freeLanes.push_back(j);
    if (!inReset) begin
      for (int k = 0; k < N; k++) begin
        int id;
        id = (mPtr + k) % N;
        if (q[id].size() > 0 && grants.size() < freeLanes.size()) grants.push_back(id);
      end
    end
    expRead = '0;
    foreach (grants[g]) expRead[grants[g]] = 1'b1;
    for (int j = 0; j < M; j++) expWrite[j] = mVld[j];
    checkValue("read", DW'(read), DW'(expRead));
    checkValue("write", DW'(write), DW'(expWrite));
    for (int j = 0; j < M; j++) begin
      if (mVld[j] || inReset) checkValue($sformatf("dout%0d", j), dout[j*DW +: DW], mVld[j] ? mData[j] : '0);
    end
    lastRead = read;
  endtask

  task automatic updateModel();
    if (inReset) begin
      for (int j = 0; j < M; j++) begin mVld[j] = 0; mData[j] = '0; end
      mPtr = 0;
      return;
    end
    for (int j = 0; j < M; j++) mVld[j] = mVld[j] && !fullCfg[j];
    foreach (grants[g]) begin
      mVld[freeLanes[g]]  = 1;
      mData[freeLanes[g]] = q[grants[g]].pop_front();
      popCount[grants[g]]++;
    end
    if (grants.size() > 0) mPtr = (grants[grants.size()-1] + 1) % N;
  endtask

  task automatic step();
    @(negedge clk);
    applyStimulus();
    #1;
    checkOutput();
    @(posedge clk);
    updateModel();
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    mPtr    = 0;
    for (int j = 0; j < M; j++) begin mVld[j] = 0; mData[j] = '0; end
    for (int i = 0; i < N; i++) popCount[i] = 0;

    // Reset is held with every queue nonempty and every lane ready.
    inReset = 1;
    fullCfg = '1;
    for (int i = 0; i < N; i++) for (int n = 0; n < 8; n++) pushItem(i);
    applyStimulus();
    step();
    step();

    // First cycle after release: queues 0 and 1 are granted, so read is 110 in [0:N-1] order.
    inReset = 0;
    for (int i = 0; i < N; i++) popCount[i] = 0;
    step();
    checkValue("firstGrant", DW'(lastRead), DW'(3'b011));
    for (int c = 0; c < 5; c++) step();
    for (int i = 0; i < N; i++) checkValue($sformatf("pops%0d", i), popCount[i], 4);

    // Only queue 2 has data: one pop per cycle, lane 0 only.
    for (int i = 0; i < N; i++) q[i].delete();
    q[2].push_back(32'h0000_00A2);
    q[2].push_back(32'h0000_00B2);
    q[2].push_back(32'h0000_00C2);
    q[2].push_back(32'h0000_00D2);
    q[2].push_back(32'h0000_00E2);
    for (int c = 0; c < 8; c++) step();

    // Stall: both slots valid, no lane ready, then only lane 0 reopens.
    for (int i = 0; i < N; i++) for (int n = 0; n < 4; n++) pushItem(i);
    fullCfg = 2'b11;
    step();
    step();
    fullCfg = 2'b00;
    for (int c = 0; c < 3; c++) begin
      step();
      checkValue("stallRead", DW'(lastRead), '0);
    end
    fullCfg = 2'b01;
    step();
    checkValue("reopenPops", $countones(lastRead), 1);

    // Reset pulse while both slots are valid: write must drop without waiting for a clock edge.
    fullCfg = 2'b00;
    step();
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    checkValue("asyncWrite", DW'(write), '0);
    checkValue("asyncRead", DW'(read), '0);
    inReset = 1;
    @(posedge clk);
    updateModel();
    step();
    inReset = 0;
    fullCfg = 2'b11;
    for (int i = 0; i < N; i++) while (q[i].size() < 3) pushItem(i);
    step();
    checkValue("postResetGrant", DW'(lastRead), DW'(3'b011));

    // Random queue refills and random lane readiness.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (q[i].size() < 5 && $urandom_range(0, 2) != 0) pushItem(i);
      fullCfg = M'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
